// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the gen2 multicycle MIPS controller: state/ALU/error encodings,
// opcode and funct constants, datapath control words and decode helpers.
package mc_ctrl_pkg;

  typedef enum logic [4:0] {
    S_IF     = 5'd0,  S_ID     = 5'd1,  S_EX_R   = 5'd2,  S_EX_MEM = 5'd3,
    S_EX_I   = 5'd4,  S_LUI_WB = 5'd5,  S_EX_BEQ = 5'd6,  S_EX_BNE = 5'd7,
    S_EX_JR  = 5'd8,  S_EX_JAL = 5'd9,  S_EX_J   = 5'd10, S_MEM_RD = 5'd11,
    S_MEM_WR = 5'd12, S_WB_R   = 5'd13, S_WB_I   = 5'd14, S_WB_LW  = 5'd15,
    S_ERROR  = 5'd16, S_EXC    = 5'd17
  } state_t;

  typedef enum logic [2:0] {
    ALU_AND = 3'd0, ALU_OR  = 3'd1, ALU_ADD = 3'd2, ALU_XOR = 3'd3,
    ALU_NOR = 3'd4, ALU_SRL = 3'd5, ALU_SUB = 3'd6, ALU_SLT = 3'd7
  } alu_op_t;

  typedef enum logic [1:0] {
    ERR_NONE = 2'b00, ERR_ILLEGAL = 2'b01, ERR_TIMEOUT = 2'b10, ERR_OVERFLOW = 2'b11
  } err_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03, OP_BEQ  = 6'h04,
                         OP_BNE   = 6'h05, OP_ADDI = 6'h08, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B,
                         OP_ANDI  = 6'h0C, OP_ORI  = 6'h0D, OP_XORI = 6'h0E, OP_LUI  = 6'h0F,
                         OP_LW    = 6'h23, OP_SW   = 6'h2B;

  localparam logic [5:0] FN_SRL = 6'h02, FN_JR  = 6'h08, FN_ADD = 6'h20, FN_ADDU = 6'h21,
                         FN_SUB = 6'h22, FN_SUBU = 6'h23, FN_AND = 6'h24, FN_OR  = 6'h25,
                         FN_XOR = 6'h26, FN_NOR = 6'h27, FN_SLT = 6'h2A, FN_SLTU = 6'h2B;

  // Field order: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg[2]
  //              PCSource[2] ALUSrcB[2] ALUSrcA RegWrite RegDst[2] CPU_MIO
  typedef logic [16:0] cw_t;
  localparam cw_t CW_FETCH  = {6'b100101, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 2'b00, 1'b1};
  localparam cw_t CW_ID     = {6'b000000, 2'b00, 2'b00, 2'b11, 1'b0, 1'b0, 2'b00, 1'b0};
  localparam cw_t CW_EX_R   = {6'b000000, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0};
  localparam cw_t CW_EX_ADR = {6'b000000, 2'b00, 2'b00, 2'b10, 1'b1, 1'b0, 2'b00, 1'b0};
  localparam cw_t CW_LUI_WB = {6'b000000, 2'b10, 2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0};
  localparam cw_t CW_BRANCH = {6'b010000, 2'b00, 2'b01, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0};
  localparam cw_t CW_EX_JR  = {6'b100000, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0};
  localparam cw_t CW_EX_JAL = {6'b100000, 2'b11, 2'b10, 2'b00, 1'b0, 1'b1, 2'b10, 1'b0};
  localparam cw_t CW_EX_J   = {6'b100000, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0};
  localparam cw_t CW_MEM_RD = {6'b001100, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1};
  localparam cw_t CW_MEM_WR = {6'b001010, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1};
  localparam cw_t CW_WB_R   = {6'b000000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 2'b01, 1'b0};
  localparam cw_t CW_WB_I   = {6'b000000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0};
  localparam cw_t CW_WB_LW  = {6'b000000, 2'b01, 2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0};
  localparam cw_t CW_EXC    = {6'b100000, 2'b00, 2'b11, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0};

  function automatic alu_op_t alu_from_funct(input logic [5:0] fn);
    case (fn)
      FN_SUB, FN_SUBU: return ALU_SUB;
      FN_AND:          return ALU_AND;
      FN_OR:           return ALU_OR;
      FN_XOR:          return ALU_XOR;
      FN_NOR:          return ALU_NOR;
      FN_SLT, FN_SLTU: return ALU_SLT;
      FN_SRL:          return ALU_SRL;
      default:         return ALU_ADD;
    endcase
  endfunction

  function automatic alu_op_t alu_from_imm_op(input logic [5:0] op);
    case (op)
      OP_SLTI, OP_SLTIU: return ALU_SLT;
      OP_ANDI:           return ALU_AND;
      OP_ORI:            return ALU_OR;
      OP_XORI:           return ALU_XOR;
      default:           return ALU_ADD;
    endcase
  endfunction

  function automatic logic imm_zero_ext(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// MIO wait-cycle counter; expire pulses on the waiting cycle that reaches LIMIT.
// LIMIT = 0 removes the counter so waits are unbounded.
module mc_wait_timer #(
  parameter int unsigned LIMIT = 16,
  parameter int unsigned CNT_W = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);

  if (LIMIT == 0) begin : g_bypass
    logic unused_ok;
    assign unused_ok = &{1'b0, clk, reset, clr, en};
    assign expire    = 1'b0;
  end else begin : g_count
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
      if (reset || clr) cnt <= '0;
      else if (en)      cnt <= cnt + 1'b1;
    end

    assign expire = en && (cnt == CNT_W'(LIMIT - 1));
  end

endmodule

// File: rtl/mc_controller_gen2.sv
// Multicycle MIPS control FSM (gen2), Moore outputs registered with the state.
// Define MCTRL_EXC_EN to add the overflow/error exception state EXC.
module mc_controller_gen2
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned ALUOP_W     = 3,
  parameter int unsigned STATE_W     = 5,
  parameter int unsigned MIO_TIMEOUT = 16,
  parameter int unsigned TMO_W       = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        Inst_in,
  input  logic               zero,
  input  logic               overflow,
  input  logic               MIO_ready,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               IorD,
  output logic               CPU_MIO,
  output logic               RegWrite,
  output logic [1:0]         RegDst,
  output logic [1:0]         MemtoReg,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSource,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               Branch,
  output logic               ExtZero,
  output logic [ALUOP_W-1:0] ALU_operation,
  output logic [STATE_W-1:0] state_out,
  output logic [1:0]         err
);

  state_t     state;
  cw_t        cw;
  alu_op_t    alu_op;
  err_t       err_r;
  logic       branch_r, ext_zero_r;
  logic       in_wait, tmo_expire, ovf_trap;
  logic [5:0] opcode, funct;

  assign opcode  = Inst_in[31:26];
  assign funct   = Inst_in[5:0];
  assign in_wait = (state == S_IF) || (state == S_MEM_RD) || (state == S_MEM_WR);

  // Clearing whenever MIO_ready is seen covers entry: a wait state is always left on ready.
  mc_wait_timer #(.LIMIT(MIO_TIMEOUT), .CNT_W(TMO_W)) u_wait_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (!in_wait || MIO_ready),
    .en     (in_wait && !MIO_ready),
    .expire (tmo_expire)
  );

`ifdef MCTRL_EXC_EN
  assign ovf_trap = overflow &&
                    (((state == S_EX_R) && ((funct == FN_ADD) || (funct == FN_SUB))) ||
                     ((state == S_EX_I) && (opcode == OP_ADDI)));
  logic unused_ok;
  assign unused_ok = &{1'b0, zero, Inst_in[25:6]};
`else
  assign ovf_trap = 1'b0;
  logic unused_ok;
  assign unused_ok = &{1'b0, zero, overflow, Inst_in[25:6]};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IF;
      cw         <= CW_FETCH;
      alu_op     <= ALU_ADD;
      branch_r   <= 1'b0;
      ext_zero_r <= 1'b0;
      err_r      <= ERR_NONE;
    end else begin
      branch_r   <= 1'b0;
      ext_zero_r <= 1'b0;
      case (state)
        S_IF: begin
          if (MIO_ready) begin
            state  <= S_ID;
            cw     <= CW_ID;
            alu_op <= ALU_ADD;
            err_r  <= ERR_NONE;
          end else if (tmo_expire) begin
            state <= S_ERROR;
            cw    <= '0;
            err_r <= ERR_TIMEOUT;
          end
        end
        S_ID: begin
          alu_op <= ALU_ADD;
          case (opcode)
            OP_RTYPE: begin
              if (funct == FN_JR) begin
                state <= S_EX_JR;
                cw    <= CW_EX_JR;
              end else begin
                state  <= S_EX_R;
                cw     <= CW_EX_R;
                alu_op <= alu_from_funct(funct);
              end
            end
            OP_LW, OP_SW: begin state <= S_EX_MEM; cw <= CW_EX_ADR; end
            OP_BEQ: begin
              state    <= S_EX_BEQ;
              cw       <= CW_BRANCH;
              alu_op   <= ALU_SUB;
              branch_r <= 1'b1;
            end
            OP_BNE:  begin state <= S_EX_BNE; cw <= CW_BRANCH; alu_op <= ALU_SUB; end
            OP_J:    begin state <= S_EX_J;   cw <= CW_EX_J;   end
            OP_JAL:  begin state <= S_EX_JAL; cw <= CW_EX_JAL; end
            OP_LUI:  begin state <= S_LUI_WB; cw <= CW_LUI_WB; end
            OP_ADDI, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
              state      <= S_EX_I;
              cw         <= CW_EX_ADR;
              alu_op     <= alu_from_imm_op(opcode);
              ext_zero_r <= imm_zero_ext(opcode);
            end
            default: begin state <= S_ERROR; cw <= '0; err_r <= ERR_ILLEGAL; end
          endcase
        end
        S_EX_R, S_EX_I: begin
          if (ovf_trap) begin
            state <= S_EXC;
            cw    <= CW_EXC;
            err_r <= ERR_OVERFLOW;
          end else begin
            state <= (state == S_EX_R) ? S_WB_R : S_WB_I;
            cw    <= (state == S_EX_R) ? CW_WB_R : CW_WB_I;
          end
        end
        S_EX_MEM: begin
          state <= (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
          cw    <= (opcode == OP_LW) ? CW_MEM_RD : CW_MEM_WR;
        end
        S_MEM_RD: begin
          if (MIO_ready) begin
            state <= S_WB_LW;
            cw    <= CW_WB_LW;
          end else if (tmo_expire) begin
            state <= S_ERROR;
            cw    <= '0;
            err_r <= ERR_TIMEOUT;
          end
        end
        S_MEM_WR: begin
          if (MIO_ready) begin
            state  <= S_IF;
            cw     <= CW_FETCH;
            alu_op <= ALU_ADD;
          end else if (tmo_expire) begin
            state <= S_ERROR;
            cw    <= '0;
            err_r <= ERR_TIMEOUT;
          end
        end
        S_WB_R, S_WB_I, S_WB_LW, S_LUI_WB, S_EX_BEQ, S_EX_BNE,
        S_EX_JR, S_EX_JAL, S_EX_J, S_EXC: begin
          state  <= S_IF;
          cw     <= CW_FETCH;
          alu_op <= ALU_ADD;
        end
        S_ERROR: begin
`ifdef MCTRL_EXC_EN
          state <= S_EXC;
          cw    <= CW_EXC;
`endif
        end
        default: begin state <= S_ERROR; cw <= '0; end
      endcase
    end
  end

  assign {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
          PCSource, ALUSrcB, ALUSrcA, RegWrite, RegDst, CPU_MIO} = cw;
  assign Branch        = branch_r;
  assign ExtZero       = ext_zero_r;
  assign ALU_operation = ALUOP_W'(alu_op);
  assign state_out     = STATE_W'(state);
  assign err           = err_r;

endmodule

// File: tb/tb_mc_controller_gen2.sv
// Scoreboard bench for mc_controller_gen2 (MIO_TIMEOUT=4): stimulus queues per-cycle
// expectations, a negedge monitor pops and compares them.
module tb_mc_controller_gen2;

  localparam logic [4:0] ST_IF = 5'd0, ST_ID = 5'd1, ST_EXR = 5'd2, ST_EXMEM = 5'd3,
                         ST_EXI = 5'd4, ST_LUI = 5'd5, ST_BEQ = 5'd6, ST_BNE = 5'd7,
                         ST_JR = 5'd8, ST_JAL = 5'd9, ST_J = 5'd10, ST_MRD = 5'd11,
                         ST_MWR = 5'd12, ST_WBR = 5'd13, ST_WBI = 5'd14, ST_WBLW = 5'd15,
                         ST_ERR = 5'd16, ST_EXC = 5'd17;
  localparam logic [2:0] A_AND = 3'd0, A_OR = 3'd1, A_ADD = 3'd2, A_XOR = 3'd3,
                         A_NOR = 3'd4, A_SRL = 3'd5, A_SUB = 3'd6, A_SLT = 3'd7;
  localparam logic [16:0] W_FETCH = 17'h12821, W_ID = 17'h00060, W_EXR = 17'h00010,
                          W_ADR = 17'h00050, W_MRD = 17'h06001, W_MWR = 17'h05001,
                          W_WBR = 17'h0000A, W_WBI = 17'h00008, W_WBLW = 17'h00208,
                          W_EXC = 17'h10180, W_ERR = 17'h00000;

  typedef struct {
    int          cyc;
    logic [4:0]  st;
    logic [16:0] cw;
    logic [2:0]  alu;
    logic        br;
    logic        ez;
    logic [1:0]  er;
    string       nm;
  } exp_t;

  logic        clk = 1'b0, reset, zero, overflow, MIO_ready;
  logic [31:0] inst;
  logic        MemRead, MemWrite, IRWrite, IorD, CPU_MIO, RegWrite, ALUSrcA;
  logic        PCWrite, PCWriteCond, Branch, ExtZero;
  logic [1:0]  RegDst, MemtoReg, ALUSrcB, PCSource, err;
  logic [2:0]  ALU_operation;
  logic [4:0]  state_out;

  exp_t q[$];
  exp_t me;
  int   cyc = 0, total = 0, bad = 0;
  logic [28:0] act, want;

  mc_controller_gen2 #(.ALUOP_W(3), .STATE_W(5), .MIO_TIMEOUT(4), .TMO_W(5)) dut (
    .clk(clk), .reset(reset), .Inst_in(inst), .zero(zero), .overflow(overflow),
    .MIO_ready(MIO_ready), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .IorD(IorD), .CPU_MIO(CPU_MIO), .RegWrite(RegWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .Branch(Branch), .ExtZero(ExtZero),
    .ALU_operation(ALU_operation), .state_out(state_out), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      me   = q.pop_front();
      act  = {state_out, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
              PCSource, ALUSrcB, ALUSrcA, RegWrite, RegDst, CPU_MIO,
              ALU_operation, Branch, ExtZero, err};
      want = {me.st, me.cw, me.alu, me.br, me.ez, me.er};
      total = total + 1;
      if (me.cyc != cyc || act !== want) begin
        bad = bad + 1;
        $display("FAIL %s cyc=%0d: got st=%0d cw=%h alu=%0d br=%b ez=%b err=%b, want st=%0d cw=%h alu=%0d br=%b ez=%b err=%b",
                 me.nm, cyc, act[28:24], act[23:7], act[6:4], act[3], act[2], act[1:0],
                 me.st, me.cw, me.alu, me.br, me.ez, me.er);
      end
    end
  end

  // Drive inputs for the coming edge and queue the state/outputs expected after it.
  task automatic step(input logic r, input logic rdy, input logic ovf, input logic [4:0] st,
                      input logic [16:0] w, input logic [2:0] a, input logic br,
                      input logic ez, input logic [1:0] er, input string nm);
    exp_t e;
    reset = r; MIO_ready = rdy; overflow = ovf;
    e.cyc = cyc + 1; e.st = st; e.cw = w; e.alu = a; e.br = br; e.ez = ez; e.er = er; e.nm = nm;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic to_id();
    step(0, 1, 0, ST_ID, W_ID, A_ADD, 0, 0, 2'b00, "if_to_id");
  endtask

  task automatic to_if();
    step(0, 1, 0, ST_IF, W_FETCH, A_ADD, 0, 0, 2'b00, "back_to_if");
  endtask

  logic [5:0]  rfn  [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h02};
  logic [2:0]  ralu [8] = '{A_ADD, A_SUB, A_AND, A_OR, A_XOR, A_NOR, A_SLT, A_SRL};
  logic [5:0]  iop  [6] = '{6'h08, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E};
  logic [2:0]  ialu [6] = '{A_ADD, A_SLT, A_SLT, A_AND, A_OR, A_XOR};
  logic        iez  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [31:0] jinst[6] = '{32'h10220003, 32'h14220003, 32'h08000010, 32'h0C000010,
                            32'h03E00008, 32'h3C011234};
  logic [4:0]  jst  [6] = '{ST_BEQ, ST_BNE, ST_J, ST_JAL, ST_JR, ST_LUI};
  logic [16:0] jcw  [6] = '{17'h08090, 17'h08090, 17'h10100, 17'h1070C, 17'h10010, 17'h00408};
  logic [2:0]  jalu [6] = '{A_SUB, A_SUB, A_ADD, A_ADD, A_ADD, A_ADD};
  logic        jbr  [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    inst = 32'h0; zero = 1'b0;
    step(1, 1, 0, ST_IF, W_FETCH, A_ADD, 0, 0, 2'b00, "reset0");
    step(1, 1, 0, ST_IF, W_FETCH, A_ADD, 0, 0, 2'b00, "reset1");

    // R-type: first fetch also stalls two cycles on MIO_ready
    inst = 32'h00221820;
    step(0, 0, 0, ST_IF, W_FETCH, A_ADD, 0, 0, 2'b00, "if_wait0");
    step(0, 0, 0, ST_IF, W_FETCH, A_ADD, 0, 0, 2'b00, "if_wait1");
    for (int i = 0; i < 8; i++) begin
      inst = 32'h00221800 | {26'd0, rfn[i]};
      to_id();
      step(0, 1, 0, ST_EXR, W_EXR, ralu[i], 0, 0, 2'b00, $sformatf("r_ex%0d", i));
      step(0, 1, 0, ST_WBR, W_WBR, ralu[i], 0, 0, 2'b00, $sformatf("r_wb%0d", i));
      to_if();
    end

    for (int i = 0; i < 6; i++) begin
      inst = {iop[i], 5'd0, 5'd2, 16'h00FF};
      to_id();
      step(0, 1, 0, ST_EXI, W_ADR, ialu[i], 0, iez[i], 2'b00, $sformatf("i_ex%0d", i));
      step(0, 1, 0, ST_WBI, W_WBI, ialu[i], 0, 0, 2'b00, $sformatf("i_wb%0d", i));
      to_if();
    end

    // lw: three idle cycles in MEM_RD, ready arrives on the cycle the count would expire
    inst = 32'h8C220004;
    to_id();
    step(0, 1, 0, ST_EXMEM, W_ADR, A_ADD, 0, 0, 2'b00, "lw_ex");
    step(0, 0, 0, ST_MRD, W_MRD, A_ADD, 0, 0, 2'b00, "lw_mem");
    for (int i = 0; i < 3; i++)
      step(0, 0, 0, ST_MRD, W_MRD, A_ADD, 0, 0, 2'b00, $sformatf("lw_wait%0d", i));
    step(0, 1, 0, ST_WBLW, W_WBLW, A_ADD, 0, 0, 2'b00, "lw_wb");
    to_if();

    inst = 32'hAC220004;
    to_id();
    step(0, 1, 0, ST_EXMEM, W_ADR, A_ADD, 0, 0, 2'b00, "sw_ex");
    step(0, 0, 0, ST_MWR, W_MWR, A_ADD, 0, 0, 2'b00, "sw_mem");
    step(0, 0, 0, ST_MWR, W_MWR, A_ADD, 0, 0, 2'b00, "sw_wait");
    step(0, 1, 0, ST_IF, W_FETCH, A_ADD, 0, 0, 2'b00, "sw_done");

    for (int i = 0; i < 6; i++) begin
      inst = jinst[i];
      to_id();
      step(0, 1, 0, jst[i], jcw[i], jalu[i], jbr[i], 0, 2'b00, $sformatf("jb_ex%0d", i));
      to_if();
    end

    // overflowing add
    inst = 32'h00221820;
    to_id();
    step(0, 1, 0, ST_EXR, W_EXR, A_ADD, 0, 0, 2'b00, "ovf_ex");
`ifdef MCTRL_EXC_EN
    step(0, 1, 1, ST_EXC, W_EXC, A_ADD, 0, 0, 2'b11, "ovf_exc");
    step(0, 1, 0, ST_IF, W_FETCH, A_ADD, 0, 0, 2'b11, "ovf_err_held");
`else
    step(0, 1, 1, ST_WBR, W_WBR, A_ADD, 0, 0, 2'b00, "ovf_ignored");
    to_if();
`endif

    // reset in the middle of a memory wait
    inst = 32'h8C220004;
    to_id();
    step(0, 1, 0, ST_EXMEM, W_ADR, A_ADD, 0, 0, 2'b00, "rst_lw_ex");
    step(0, 0, 0, ST_MRD, W_MRD, A_ADD, 0, 0, 2'b00, "rst_lw_mem");
    step(1, 0, 0, ST_IF, W_FETCH, A_ADD, 0, 0, 2'b00, "reset_mid_wait");

    inst = 32'hFC000000;
    to_id();
    step(0, 1, 0, ST_ERR, W_ERR, A_ADD, 0, 0, 2'b01, "illegal_op");
`ifdef MCTRL_EXC_EN
    step(0, 1, 0, ST_EXC, W_EXC, A_ADD, 0, 0, 2'b01, "illegal_exc");
    step(0, 1, 0, ST_IF, W_FETCH, A_ADD, 0, 0, 2'b01, "illegal_to_if");
`else
    step(0, 1, 0, ST_ERR, W_ERR, A_ADD, 0, 0, 2'b01, "illegal_sticky0");
    step(0, 1, 0, ST_ERR, W_ERR, A_ADD, 0, 0, 2'b01, "illegal_sticky1");
`endif
    step(1, 1, 0, ST_IF, W_FETCH, A_ADD, 0, 0, 2'b00, "reset_clears_err");

    // fetch timeout: four waiting cycles in IF
    for (int i = 0; i < 3; i++)
      step(0, 0, 0, ST_IF, W_FETCH, A_ADD, 0, 0, 2'b00, $sformatf("tmo_wait%0d", i));
    step(0, 0, 0, ST_ERR, W_ERR, A_ADD, 0, 0, 2'b10, "timeout");
`ifdef MCTRL_EXC_EN
    step(0, 1, 0, ST_EXC, W_EXC, A_ADD, 0, 0, 2'b10, "timeout_exc");
    step(0, 1, 0, ST_IF, W_FETCH, A_ADD, 0, 0, 2'b10, "timeout_to_if");
`else
    step(0, 1, 0, ST_ERR, W_ERR, A_ADD, 0, 0, 2'b10, "timeout_sticky");
`endif

    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      total = total + 1;
      bad   = bad + 1;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
